// File: rtl/stage_one_prep_if.sv
// Handshake and result bus between a driver and the stage_one_prep front-end stage.
// The master drives the request side; the stage (slave) returns the results.
interface stage_one_prep_if #(
   parameter int FLT_DATA_WIDTH = 32,
   parameter int CRD_DATA_WIDTH = 22
);
   logic                      clk_en;
   logic                      start;
   logic                      sub_en;
   logic [FLT_DATA_WIDTH-1:0] x;
   logic                      busy;
   logic [FLT_DATA_WIDTH-1:0] half;
   logic [FLT_DATA_WIDTH-1:0] square;
   logic [CRD_DATA_WIDTH-1:0] x_to_cordic;
   logic                      sat;
   logic                      done;

   modport master (
      output clk_en, start, sub_en, x,
      input  busy, half, square, x_to_cordic, sat, done
   );

   modport slave (
      input  clk_en, start, sub_en, x,
      output busy, half, square, x_to_cordic, sat, done
   );
endinterface

// File: rtl/stage_one_prep.sv
// Front-end stage for the CORDIC sum datapath: from one float operand it produces
// x/2, x*x (pipelined multiplier) and a saturated, offset fixed-point word.
module stage_one_prep #(
   parameter int FLT_DATA_WIDTH = 32,
   parameter int CRD_DATA_WIDTH = 22,
   parameter int FRAC_BITS      = 20,
   parameter int SCALE_SHIFT    = 7,
   parameter logic signed [CRD_DATA_WIDTH:0] OFFSET = (CRD_DATA_WIDTH+1)'(1 << FRAC_BITS),
   parameter int MUL_LATENCY    = 5,
   parameter int CONV_LATENCY   = 1,
   parameter int COUNTER_WIDTH  = 10
) (
   input logic            clk,
   input logic            rst,
   stage_one_prep_if.slave bus
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] MUL  = 2'd1;
   localparam logic [1:0] CONV = 2'd2;

   // VW holds V and R with headroom; MW holds the shifted significand before clipping.
   localparam int VW = CRD_DATA_WIDTH + 2;
   localparam int MW = 24 + CRD_DATA_WIDTH + 2;

   localparam logic signed [VW-1:0] V_MAX   = (VW'(1) << CRD_DATA_WIDTH) - VW'(1);
   localparam logic signed [VW-1:0] V_MIN   = ~V_MAX;
   localparam logic signed [VW-1:0] R_MAX   = (VW'(1) << (CRD_DATA_WIDTH-1)) - VW'(1);
   localparam logic signed [VW-1:0] R_MIN   = ~R_MAX;
   localparam logic        [MW-1:0] POS_LIM = (MW'(1) << CRD_DATA_WIDTH) - MW'(1);
   localparam logic        [MW-1:0] NEG_LIM = MW'(1) << CRD_DATA_WIDTH;
   localparam logic signed [VW-1:0] OFF_EXT = $signed({OFFSET[CRD_DATA_WIDTH], OFFSET});
   localparam logic [COUNTER_WIDTH-1:0] MUL_LD  = COUNTER_WIDTH'(MUL_LATENCY);
   localparam logic [COUNTER_WIDTH-1:0] CONV_LD = COUNTER_WIDTH'(CONV_LATENCY);

   function automatic logic [FLT_DATA_WIDTH-1:0] f_half(input logic [FLT_DATA_WIDTH-1:0] a);
      logic [7:0] e;
      e = a[30:23];
      if (e == 8'hFF)      return a;
      else if (e <= 8'd1)  return {a[31], 31'd0};
      else                 return {a[31], e - 8'd1, a[22:0]};
   endfunction

   // Square with round-to-nearest-even; denormal inputs and underflow flush to +0.
   function automatic logic [FLT_DATA_WIDTH-1:0] f_square(input logic [FLT_DATA_WIDTH-1:0] a);
      logic [7:0]         e;
      logic [23:0]        s;
      logic [47:0]        m;
      logic signed [10:0] er;
      logic [23:0]        mt;
      logic               g;
      logic               st;
      logic [24:0]        r;
      logic [22:0]        frac;
      e = a[30:23];
      if (e == 8'hFF) return (a[22:0] == 23'd0) ? 32'h7F80_0000 : 32'h7FC0_0000;
      if (e == 8'h00) return 32'h0000_0000;
      s  = {1'b1, a[22:0]};
      m  = {24'd0, s} * {24'd0, s};
      er = $signed({2'b00, e, 1'b0}) - 11'sd127;
      if (m[47]) begin
         mt = m[47:24];
         g  = m[23];
         st = |m[22:0];
         er = er + 11'sd1;
      end else begin
         mt = m[46:23];
         g  = m[22];
         st = |m[21:0];
      end
      r = {1'b0, mt} + {24'd0, g & (st | mt[0])};
      if (r[24]) begin
         frac = r[23:1];
         er   = er + 11'sd1;
      end else begin
         frac = r[22:0];
      end
      if (er >= 11'sd255)    return 32'h7F80_0000;
      else if (er <= 11'sd0) return 32'h0000_0000;
      else                   return {1'b0, er[7:0], frac};
   endfunction

   // Returns {clip, V}: x scaled by 2^(FRAC_BITS-SCALE_SHIFT), truncated toward zero.
   function automatic logic [VW:0] to_fixed(input logic [FLT_DATA_WIDTH-1:0] a);
      logic [7:0]          e;
      logic [MW-1:0]       mag;
      logic                big;
      int                  sh;
      logic signed [VW-1:0] v;
      logic                clip;
      e    = a[30:23];
      mag  = '0;
      big  = 1'b0;
      clip = 1'b0;
      v    = '0;
      sh   = int'({24'd0, e}) - 150 - SCALE_SHIFT + FRAC_BITS;
      if (e == 8'hFF) begin
         clip = 1'b1;
         v    = (a[31] && a[22:0] == 23'd0) ? V_MIN : V_MAX;
      end else if (e != 8'h00) begin
         if (sh >= CRD_DATA_WIDTH + 2) big = 1'b1;
         else if (sh >= 0)             mag = MW'({1'b1, a[22:0]}) << sh;
         else if (sh > -24)            mag = MW'({1'b1, a[22:0]}) >> (-sh);
         if (a[31]) begin
            if (big || mag > NEG_LIM) begin clip = 1'b1; v = V_MIN; end
            else                      v = -$signed(mag[VW-1:0]);
         end else begin
            if (big || mag > POS_LIM) begin clip = 1'b1; v = V_MAX; end
            else                      v = $signed(mag[VW-1:0]);
         end
      end
      return {clip, v};
   endfunction

   // Returns {clip, R} with R clipped to the signed CRD_DATA_WIDTH range.
   function automatic logic [CRD_DATA_WIDTH:0] sat_crd(input logic signed [VW-1:0] r);
      if (r > R_MAX)      return {1'b1, R_MAX[CRD_DATA_WIDTH-1:0]};
      else if (r < R_MIN) return {1'b1, R_MIN[CRD_DATA_WIDTH-1:0]};
      else                return {1'b0, r[CRD_DATA_WIDTH-1:0]};
   endfunction

   logic [1:0]                state_q, state_d;
   logic [COUNTER_WIDTH-1:0]  cnt_q, cnt_d;
   logic [FLT_DATA_WIDTH-1:0] x_q, x_d;
   logic                      sub_q, sub_d;
   logic                      done_q, done_d;
   logic                      load_mid, load_out;
   logic [FLT_DATA_WIDTH-1:0] sq_pipe_q [MUL_LATENCY];
   logic [FLT_DATA_WIDTH-1:0] half_mid_q;
   logic [CRD_DATA_WIDTH-1:0] xc_mid_q;
   logic                      sat_mid_q;
   logic [FLT_DATA_WIDTH-1:0] half_q, square_q;
   logic [CRD_DATA_WIDTH-1:0] xc_q;
   logic                      sat_q;

   logic [VW:0]               fix_c;
   logic signed [VW-1:0]      r_c;
   logic [CRD_DATA_WIDTH:0]   rs_c;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      x_d      = x_q;
      sub_d    = sub_q;
      done_d   = 1'b0;
      load_mid = 1'b0;
      load_out = 1'b0;
      case (state_q)
         IDLE: if (bus.start) begin
            state_d = MUL;
            cnt_d   = MUL_LD;
            x_d     = bus.x;
            sub_d   = bus.sub_en;
         end
         MUL: if (cnt_q == COUNTER_WIDTH'(1)) begin
            state_d  = CONV;
            cnt_d    = CONV_LD;
            load_mid = 1'b1;
         end else begin
            cnt_d = cnt_q - COUNTER_WIDTH'(1);
         end
         CONV: if (cnt_q == COUNTER_WIDTH'(1)) begin
            state_d  = IDLE;
            cnt_d    = '0;
            done_d   = 1'b1;
            load_out = 1'b1;
         end else begin
            cnt_d = cnt_q - COUNTER_WIDTH'(1);
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      fix_c = to_fixed(x_q);
      r_c   = $signed(fix_c[VW-1:0]) - (sub_q ? OFF_EXT : VW'(0));
      rs_c  = sat_crd(r_c);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         half_q   <= '0;
         square_q <= '0;
         xc_q     <= '0;
         sat_q    <= 1'b0;
      end else if (bus.clk_en) begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         if (load_out) begin
            half_q   <= half_mid_q;
            square_q <= sq_pipe_q[MUL_LATENCY-1];
            xc_q     <= xc_mid_q;
            sat_q    <= sat_mid_q;
         end
      end
   end

   // Operand latch and exponent-arithmetic results, captured on the MUL->CONV edge.
   always_ff @(posedge clk) begin
      if (bus.clk_en) begin
         x_q   <= x_d;
         sub_q <= sub_d;
         if (load_mid) begin
            half_mid_q <= f_half(x_q);
            xc_mid_q   <= rs_c[CRD_DATA_WIDTH-1:0];
            sat_mid_q  <= fix_c[VW] | rs_c[CRD_DATA_WIDTH];
         end
      end
   end

   // Multiplier pipeline, cleared by rst and frozen with clk_en.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MUL_LATENCY; i++) sq_pipe_q[i] <= '0;
      end else if (bus.clk_en) begin
         sq_pipe_q[0] <= f_square(x_q);
         for (int i = 1; i < MUL_LATENCY; i++) sq_pipe_q[i] <= sq_pipe_q[i-1];
      end
   end

   assign bus.busy        = (state_q != IDLE);
   assign bus.done        = done_q;
   assign bus.half        = half_q;
   assign bus.square      = square_q;
   assign bus.x_to_cordic = xc_q;
   assign bus.sat         = sat_q;

endmodule

// File: tb/tb_stage_one_prep.sv
// Bench for stage_one_prep: table of operands with hand-derived results, a scoreboard
// queue matched against done pulses, and sequences for stall, handshake and reset abort.
module tb_stage_one_prep;

   typedef struct {
      logic [31:0] x;
      logic        sub;
      logic [31:0] h;
      logic [31:0] sq;
      logic [21:0] xc;
      logic        sat;
   } vec_t;

   typedef struct {
      logic [31:0] h;
      logic [31:0] sq;
      logic [21:0] xc;
      logic        sat;
      int          exp_cyc;
   } exp_t;

   localparam int NV = 16;

   logic clk = 1'b0;
   logic rst;
   vec_t tab [NV];
   exp_t sb [$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   done_cnt = 0;

   stage_one_prep_if #(.FLT_DATA_WIDTH(32), .CRD_DATA_WIDTH(22)) bif ();

   stage_one_prep dut (
      .clk (clk),
      .rst (rst),
      .bus (bif)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: on every enabled edge with done high, pop and compare one result.
   initial begin
      logic en_s;
      exp_t e;
      forever begin
         @(posedge clk);
         en_s = bif.clk_en;
         #1;
         cyc++;
         if (en_s && bif.done) begin
            done_cnt++;
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
               e = sb.pop_front();
               chk("half", bif.half, e.h);
               chk("square", bif.square, e.sq);
               chk("x_to_cordic", {10'd0, bif.x_to_cordic}, {10'd0, e.xc});
               chk("sat", {31'd0, bif.sat}, {31'd0, e.sat});
               chk("latency", cyc, e.exp_cyc);
            end
         end
      end
   end

   function automatic exp_t mk_exp(input int i, input int lat);
      exp_t e;
      e.h = tab[i].h;
      e.sq = tab[i].sq;
      e.xc = tab[i].xc;
      e.sat = tab[i].sat;
      e.exp_cyc = lat;
      return e;
   endfunction

   // Called at a negedge; leaves start low at the negedge after the accept edge.
   task automatic issue(input int i, input int stall);
      int guard = 0;
      while (bif.busy && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 300) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: got busy=1 expected busy=0 within 300 cycles");
      end
      bif.x = tab[i].x;
      bif.sub_en = tab[i].sub;
      bif.start = 1'b1;
      sb.push_back(mk_exp(i, cyc + 7 + stall));
      @(negedge clk);
      bif.start = 1'b0;
   endtask

   task automatic wait_idle();
      int guard = 0;
      while ((bif.busy || sb.size() != 0) && guard < 300) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 300) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: got %0d pending results expected 0", sb.size());
         sb.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      int d0;
      int guard;
      tab[0]  = '{32'h3F800000, 1'b1, 32'h3F000000, 32'h3F800000, 22'h302000, 1'b0};
      tab[1]  = '{32'hBF000000, 1'b1, 32'hBE800000, 32'h3E800000, 22'h2FF000, 1'b0};
      tab[2]  = '{32'h43800000, 1'b1, 32'h43000000, 32'h47800000, 22'h100000, 1'b0};
      tab[3]  = '{32'h43800000, 1'b0, 32'h43000000, 32'h47800000, 22'h1FFFFF, 1'b1};
      tab[4]  = '{32'h7F800000, 1'b1, 32'h7F800000, 32'h7F800000, 22'h1FFFFF, 1'b1};
      tab[5]  = '{32'h40400000, 1'b1, 32'h3FC00000, 32'h41100000, 22'h306000, 1'b0};
      tab[6]  = '{32'h40000000, 1'b0, 32'h3F800000, 32'h40800000, 22'h004000, 1'b0};
      tab[7]  = '{32'h00000000, 1'b1, 32'h00000000, 32'h00000000, 22'h300000, 1'b0};
      tab[8]  = '{32'hFF800000, 1'b0, 32'hFF800000, 32'h7F800000, 22'h200000, 1'b1};
      tab[9]  = '{32'h7FC00000, 1'b0, 32'h7FC00000, 32'h7FC00000, 22'h1FFFFF, 1'b1};
      tab[10] = '{32'h00800000, 1'b1, 32'h00000000, 32'h00000000, 22'h300000, 1'b0};
      tab[11] = '{32'h80800000, 1'b0, 32'h80000000, 32'h00000000, 22'h000000, 1'b0};
      tab[12] = '{32'h80000000, 1'b1, 32'h80000000, 32'h00000000, 22'h300000, 1'b0};
      tab[13] = '{32'h3F800001, 1'b1, 32'h3F000001, 32'h3F800002, 22'h302000, 1'b0};
      tab[14] = '{32'h47800000, 1'b1, 32'h47000000, 32'h4F800000, 22'h1FFFFF, 1'b1};
      tab[15] = '{32'h5F800000, 1'b0, 32'h5F000000, 32'h7F800000, 22'h1FFFFF, 1'b1};

      rst = 1'b1;
      bif.clk_en = 1'b1;
      bif.start = 1'b0;
      bif.sub_en = 1'b0;
      bif.x = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, bif.busy}, 32'd0);
      chk("rst_done", {31'd0, bif.done}, 32'd0);
      chk("rst_sat", {31'd0, bif.sat}, 32'd0);
      chk("rst_half", bif.half, 32'd0);
      chk("rst_square", bif.square, 32'd0);
      chk("rst_xc", {10'd0, bif.x_to_cordic}, 32'd0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         issue(i, 0);
         wait_idle();
      end

      // Three disabled edges inside MUL push done out by three cycles.
      issue(5, 3);
      @(negedge clk);
      bif.clk_en = 1'b0;
      repeat (2) @(negedge clk);
      chk("stall_busy", {31'd0, bif.busy}, 32'd1);
      @(negedge clk);
      bif.clk_en = 1'b1;
      wait_idle();

      // start held high while busy must not queue a second operation.
      d0 = done_cnt;
      bif.x = tab[2].x;
      bif.sub_en = tab[2].sub;
      bif.start = 1'b1;
      sb.push_back(mk_exp(2, cyc + 7));
      repeat (4) @(negedge clk);
      bif.start = 1'b0;
      wait_idle();
      repeat (10) @(negedge clk);
      chk("held_start_dones", done_cnt - d0, 1);

      // start during the done cycle issues back to back.
      d0 = done_cnt;
      issue(1, 0);
      guard = 0;
      while (!bif.done && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("b2b_first_done", {31'd0, bif.done}, 32'd1);
      chk("b2b_idle_in_done", {31'd0, bif.busy}, 32'd0);
      issue(4, 0);
      wait_idle();
      chk("b2b_dones", done_cnt - d0, 2);

      // Reset two cycles after accept aborts and clears the previous results.
      d0 = done_cnt;
      issue(3, 0);
      @(negedge clk);
      rst = 1'b1;
      sb.delete();
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", {31'd0, bif.busy}, 32'd0);
      chk("abort_half", bif.half, 32'd0);
      chk("abort_square", bif.square, 32'd0);
      chk("abort_xc", {10'd0, bif.x_to_cordic}, 32'd0);
      chk("abort_sat", {31'd0, bif.sat}, 32'd0);
      repeat (10) @(negedge clk);
      chk("abort_no_done", done_cnt - d0, 0);
      issue(0, 0);
      wait_idle();
      chk("after_abort_dones", done_cnt - d0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
